// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with watchdog.
// Define MEM_BUS_ARB_RR_EN for round-robin; default is fixed data-over-fetch priority.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic                  if_err,
  output logic [31:0]           if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  input  logic [3:0]            d_wstrb,
  output logic                  d_done,
  output logic                  d_err,
  output logic [31:0]           d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [1:0]            state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_wstrb_q, mem_wstrb_d;
  logic                  if_done_q, if_done_d;
  logic                  if_err_q, if_err_d;
  logic [31:0]           if_rdata_q, if_rdata_d;
  logic                  d_done_q, d_done_d;
  logic                  d_err_q, d_err_d;
  logic [31:0]           d_rdata_q, d_rdata_d;
  logic                  pick_if;
  logic                  fin;
  logic                  fin_err;
  logic [31:0]           fin_data;

`ifdef MEM_BUS_ARB_RR_EN
  // prio_q set means fetch wins a tie; flipped at every grant
  logic prio_q, prio_d;
  assign pick_if = if_req & (~d_req | prio_q);
`else
  assign pick_if = ~d_req;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_done_d   = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_done_d    = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    fin         = 1'b0;
    fin_err     = 1'b0;
    fin_data    = 32'h0;
`ifdef MEM_BUS_ARB_RR_EN
    prio_d      = prio_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (if_req | d_req) begin
          gnt_d       = pick_if;
          mem_req_d   = 1'b1;
          mem_we_d    = pick_if ? 1'b0 : d_we;
          mem_addr_d  = pick_if ? if_addr : d_addr;
          mem_wdata_d = d_wdata;
          mem_wstrb_d = pick_if ? 4'h0 : d_wstrb;
          state_d     = S_ISSUE;
`ifdef MEM_BUS_ARB_RR_EN
          prio_d      = ~pick_if;
`endif
        end
      end
      S_ISSUE: begin
        cnt_d   = 8'h0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack) begin
          fin      = 1'b1;
          fin_data = mem_rdata;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LIMIT) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (fin) begin
      state_d = S_RESP;
      if (gnt_q) begin
        if_done_d  = 1'b1;
        if_err_d   = fin_err;
        if_rdata_d = fin_data;
      end else begin
        d_done_d  = 1'b1;
        d_err_d   = fin_err;
        d_rdata_d = fin_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      gnt_q       <= 1'b0;
      cnt_q       <= 8'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'h0;
      if_done_q   <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_done_q    <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= 32'h0;
`ifdef MEM_BUS_ARB_RR_EN
      prio_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_done_q   <= if_done_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      d_done_q    <= d_done_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
`ifdef MEM_BUS_ARB_RR_EN
      prio_q      <= prio_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign if_done   = if_done_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_done    = d_done_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

- Shares the SoC's single memory port between the CPU instruction-fetch path and the load/store path.
- Arbitrates, registers the winning request, drives one memory transaction at a time and routes the response back to its owner.
- A watchdog terminates transactions whose memory response never arrives.
- Sits between `cpu` and the ROM/RAM inside `soc`.

## Interface

- `ADDR_WIDTH`, 32, width of all address buses.
- `TIMEOUT_CYCLES`, 255, maximum WAIT cycles before abort; 0 disables the watchdog; range 0–255.

Ports:

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request, held until `if_done`.
- `if_addr`  in  ADDR_WIDTH  fetch address.
- `if_done`  out  1  one-cycle completion pulse.
- `if_err`  out  1  valid with `if_done`; 1 = timed out.
- `if_rdata`  out  32  fetched word, valid with `if_done`.
- `d_req`  in  1  data request, held until `d_done`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_WIDTH  data address.
- `d_wdata`  in  32  store data.
- `d_wstrb`  in  4  byte enables for stores.
- `d_done`  out  1  one-cycle completion pulse.
- `d_err`  out  1  valid with `d_done`; 1 = timed out.
- `d_rdata`  out  32  load data, valid with `d_done`.
- `mem_req`  out  1  one-cycle transaction strobe.
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`  out  1/ADDR_WIDTH/32/4  registered copy of the granted request, stable from ISSUE until the end of RESP.
- `mem_ack`  in  1  memory completion; earliest one cycle after `mem_req`.
- `mem_rdata`  in  32  read data, valid with `mem_ack`.

## Operation

- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** if any request is present, choose a winner, latch its fields plus owner bit `gnt_d`, and go to ISSUE. Otherwise stay in IDLE.
- **ISSUE:** `mem_req`=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- **WAIT:**
  - On `mem_ack`: capture `mem_rdata`, clear the error flag, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES (nonzero): set the error flag, capture rdata = 0, go to RESP.
  - Otherwise increment the counter.
- **RESP:** assert the owner's `*_done` with `*_rdata`/`*_err`; go to IDLE.
- Arbitration happens only in IDLE. A request arriving in ISSUE/WAIT/RESP waits for the next IDLE.
- Requests are never dropped or reordered. A requester deasserting `*_req` after grant does not cancel the transaction; its `*_done` still pulses.
- `mem_ack` outside WAIT is ignored.
- In WAIT, `mem_ack` takes precedence over timeout in the same cycle.
- Fetches drive `mem_we`=0 and `mem_wstrb`=0; `mem_wdata` is don't-care.
- `*_rdata` holds its last value between done pulses. `*_err` is 0 outside done cycles.
- Reset (asynchronous):
  - State goes to IDLE.
  - All outputs go to 0 immediately, including `mem_req`, both dones, errs and rdatas.
  - The priority pointer is cleared to favour data.
  - Reset during ISSUE/WAIT abandons the transaction with no done pulse.

## Timing

- `*_req` sampled at edge N in IDLE → `mem_req` high in cycle N+1.
- With `mem_ack` in cycle N+1+k (k ≥ 1) → `*_done` in cycle N+2+k → IDLE in N+3+k.
- Minimum request-to-done latency is 3 cycles. Minimum issue-to-issue spacing is 4 cycles.
- Timeout with TIMEOUT_CYCLES=T: `*_done` with `*_err`=1 arrives T+2 cycles after ISSUE.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration

- `MEM_BUS_ARB_RR_EN` defined: round-robin fairness. When both requests are present in IDLE, the requester not served last wins. A single requester always wins regardless of the pointer. The pointer updates at the grant.
- `MEM_BUS_ARB_RR_EN` undefined: fixed priority, data over fetch. Continuous `d_req` may starve fetch.

## Test plan

- **Single fetch:** `if_req`, `if_addr`=0x10, `mem_ack` 1 cycle after `mem_req` with rdata 0x00500293 → `if_done` 3 cycles after the request, `if_rdata`=0x00500293, `if_err`=0, `mem_we`=0.
- **Store:** `d_req`, `d_we`=1, addr 0x200, wdata 0xDEADBEEF, wstrb 0xF → `mem_*` carries exactly these values for one `mem_req`; `d_done` follows the ack.
- **Simultaneous requests held for 3 transactions:**
  - Without RR: grants D, D, D.
  - With RR: grants D, I, D.
  - `mem_req` never asserts twice inside one transaction.
- **Watchdog:** TIMEOUT_CYCLES=4, no `mem_ack` → `d_done` with `d_err`=1, `d_rdata`=0, 6 cycles after ISSUE. A late `mem_ack` in the following IDLE is ignored.
- **Ack/timeout collision:** `mem_ack` in the same cycle the counter hits T → `*_err`=0, data delivered.
- **Reset during WAIT:** all outputs are 0 immediately and no `*_done` pulses. After release, a new `if_req` completes normally.
